memory_stage: RTL and testbench

Pipeline stage directly downstream of `execute_stage`. It registers the execute-stage control word, ALU result and store data, and runs the data-memory valid/ready handshake for loads and stores. It aligns and sign-extends load data, and produces the rd write value for writeback. It asserts a stall while a memory access is outstanding.

---
 rtl/rvga_types_pkg.sv | 31 +++
 rtl/dff.sv | 21 ++
 rtl/rvga_lsu_align.sv | 66 ++++++
 rtl/memory_stage.sv | 148 ++++++++++++++
 tb/tb_memory_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rvga_types_pkg.sv
// Shared pipeline types: control word, memory-stage FSM states, load/store funct3 codes.
package rvga_types;

    // Control word passed down the pipeline from execute.
    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_w_v;
        logic [2:0] funct3;
        logic       dmem_r_v;
        logic       dmem_w_v;
    } rvga_cword;

    localparam int unsigned cword_width_lp = $bits(rvga_cword);

    typedef enum logic [1:0] {
        mem_idle_s,
        mem_req_s,
        mem_wait_s,
        mem_done_s
    } rvga_mem_state_e;

    localparam logic [2:0] funct3_lb_lp  = 3'b000;
    localparam logic [2:0] funct3_lh_lp  = 3'b001;
    localparam logic [2:0] funct3_lw_lp  = 3'b010;
    localparam logic [2:0] funct3_lbu_lp = 3'b100;
    localparam logic [2:0] funct3_lhu_lp = 3'b101;
    localparam logic [2:0] funct3_sb_lp  = 3'b000;
    localparam logic [2:0] funct3_sh_lp  = 3'b001;
    localparam logic [2:0] funct3_sw_lp  = 3'b010;

endpackage

// File: rtl/dff.sv
// Enabled register with asynchronous active-high clear.
// Ports: clk_i, rst_i, en_i (load enable), d_i, q_o.
module dff #(
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rvga_lsu_align.sv
// Combinational load/store alignment: store lane replication and byte enables,
// load extraction with sign/zero extension, and misalignment detection.
// Ports: funct3_i, offset_i (addr[1:0]), mem_v_i (op is a load or store),
//        st_data_i, ld_word_i in; st_data_o, st_mask_o, ld_data_o, misaligned_o out.
module rvga_lsu_align
    import rvga_types::*;
#(
    parameter int unsigned width_p = 32
) (
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         offset_i,
    input  logic               mem_v_i,
    input  logic [width_p-1:0] st_data_i,
    input  logic [width_p-1:0] ld_word_i,
    output logic [width_p-1:0] st_data_o,
    output logic [3:0]         st_mask_o,
    output logic [width_p-1:0] ld_data_o,
    output logic               misaligned_o
);

    logic [width_p-1:0] byte_shift;
    logic [width_p-1:0] half_shift;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Bring the addressed byte/half down to bit 0.
    assign byte_shift = ld_word_i >> {offset_i, 3'b000};
    assign half_shift = ld_word_i >> {offset_i[1], 4'b0000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = half_shift[15:0];

    // Store byte enables and lane-replicated data.
    always_comb begin
        st_mask_o = 4'b1111;
        st_data_o = st_data_i;
        case (funct3_i[1:0])
            funct3_sb_lp[1:0]: begin
                st_mask_o = 4'b0001 << offset_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            funct3_sh_lp[1:0]: begin
                st_mask_o = 4'b0011 << offset_i;
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extension.
    always_comb begin
        ld_data_o = ld_word_i;
        case (funct3_i)
            funct3_lb_lp:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            funct3_lh_lp:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            funct3_lbu_lp: ld_data_o = {24'h0, ld_byte};
            funct3_lhu_lp: ld_data_o = {16'h0, ld_half};
            default:       ld_data_o = ld_word_i;
        endcase
    end

    // Halfwords need even offsets, words need offset 0.
    assign misaligned_o = mem_v_i &
                          (((funct3_i[1:0] == 2'b01) & offset_i[0]) |
                           ((funct3_i[1:0] == 2'b10) & (offset_i != 2'b00)));

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers execute outputs, runs the data-memory
// valid/ready handshake, aligns load data and selects the writeback value.
// Ports: clk_i, rst_i, stall_v_i, cword_i, alu_result_i, st_data_i in;
//        cword_o, rd_data_o, memory_rd_data_o, stall_v_o, misaligned_v_o out;
//        dmem_* request/response interface to data memory.
module memory_stage
    import rvga_types::*;
#(
    parameter int unsigned width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_v_i,
    input  logic [cword_width_lp-1:0] cword_i,
    input  logic [width_p-1:0]        alu_result_i,
    input  logic [width_p-1:0]        st_data_i,
    output logic [cword_width_lp-1:0] cword_o,
    output logic [width_p-1:0]        rd_data_o,
    output logic [width_p-1:0]        memory_rd_data_o,
    output logic                      stall_v_o,
    output logic                      misaligned_v_o,
    output logic                      dmem_v_o,
    output logic                      dmem_w_v_o,
    output logic [width_p-1:0]        dmem_addr_o,
    output logic [width_p-1:0]        dmem_data_o,
    output logic [3:0]                dmem_mask_o,
    input  logic                      dmem_ready_i,
    input  logic                      dmem_resp_v_i,
    input  logic [width_p-1:0]        dmem_data_i
);

    logic [cword_width_lp-1:0] cword_q;
    rvga_cword                 cword_r;
    logic [width_p-1:0]        alu_result_r;
    logic [width_p-1:0]        st_data_r;
    logic [width_p-1:0]        ld_data_r;
    rvga_mem_state_e           state_r;
    rvga_mem_state_e           accept_state;

    logic               mem_v;
    logic               pending;
    logic               misaligned;
    logic               issue;
    logic               handshake;
    logic               resp;
    logic [width_p-1:0] st_data_aligned;
    logic [3:0]         st_mask;
    logic [width_p-1:0] ld_aligned;

    // Input registers hold while the pipeline is stalled.
    dff #(.width_p(cword_width_lp)) cword_reg (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(~stall_v_i), .d_i(cword_i), .q_o(cword_q)
    );
    dff #(.width_p(width_p)) alu_reg (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(~stall_v_i), .d_i(alu_result_i), .q_o(alu_result_r)
    );
    dff #(.width_p(width_p)) st_reg (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(~stall_v_i), .d_i(st_data_i), .q_o(st_data_r)
    );

    assign cword_r = cword_q;

    rvga_lsu_align #(.width_p(width_p)) align (
        .funct3_i    (cword_r.funct3),
        .offset_i    (alu_result_r[1:0]),
        .mem_v_i     (mem_v),
        .st_data_i   (st_data_r),
        .ld_word_i   (dmem_data_i),
        .st_data_o   (st_data_aligned),
        .st_mask_o   (st_mask),
        .ld_data_o   (ld_aligned),
        .misaligned_o(misaligned)
    );

    assign mem_v     = cword_r.dmem_r_v | cword_r.dmem_w_v;
    assign pending   = mem_v & (state_r != mem_done_s);
    assign issue     = pending & ~misaligned;
    assign dmem_v_o  = ((state_r == mem_idle_s) & issue) | (state_r == mem_req_s);
    assign handshake = dmem_v_o & dmem_ready_i;
    assign resp      = (state_r == mem_wait_s) & dmem_resp_v_i;

    // Stall drops on the store handshake and on the load response cycle.
    assign stall_v_o = issue & ~(handshake & cword_r.dmem_w_v) & ~resp;

    assign misaligned_v_o   = misaligned;
    assign cword_o          = cword_q;
    assign memory_rd_data_o = alu_result_r;
    assign dmem_w_v_o       = dmem_v_o & cword_r.dmem_w_v;
    assign dmem_addr_o      = {alu_result_r[width_p-1:2], 2'b00};
    assign dmem_data_o      = dmem_v_o ? st_data_aligned : '0;
    assign dmem_mask_o      = dmem_v_o ? st_mask : 4'b0000;

    // Writeback value: bypass on response, captured data after, else ALU.
    always_comb begin
        rd_data_o = alu_result_r;
        if (cword_r.dmem_r_v & misaligned) begin
            rd_data_o = '0;
        end else if (cword_r.dmem_r_v & resp) begin
            rd_data_o = ld_aligned;
        end else if (cword_r.dmem_r_v & (state_r == mem_done_s)) begin
            rd_data_o = ld_data_r;
        end
    end

    // A completed access only parks in DONE if the instruction is still held;
    // otherwise the next instruction loads now and must start from IDLE.
    always_comb begin
        accept_state = mem_wait_s;
        if (cword_r.dmem_w_v) begin
            accept_state = stall_v_i ? mem_done_s : mem_idle_s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= mem_idle_s;
            ld_data_r <= '0;
        end else begin
            case (state_r)
                mem_idle_s: begin
                    if (issue & dmem_ready_i) begin
                        state_r <= accept_state;
                    end else if (issue) begin
                        state_r <= mem_req_s;
                    end
                end
                mem_req_s: begin
                    if (dmem_ready_i) begin
                        state_r <= accept_state;
                    end
                end
                mem_wait_s: begin
                    if (dmem_resp_v_i) begin
                        ld_data_r <= ld_aligned;
                        state_r   <= stall_v_i ? mem_done_s : mem_idle_s;
                    end
                end
                mem_done_s: begin
                    if (~stall_v_i) begin
                        state_r <= mem_idle_s;
                    end
                end
                default: state_r <= mem_idle_s;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    import rvga_types::*;

    logic                      clk;
    logic                      rst_i;
    logic                      stall_v_i;
    logic [cword_width_lp-1:0] cword_i;
    logic [31:0]               alu_result_i;
    logic [31:0]               st_data_i;
    logic [cword_width_lp-1:0] cword_o;
    logic [31:0]               rd_data_o;
    logic [31:0]               memory_rd_data_o;
    logic                      stall_v_o;
    logic                      misaligned_v_o;
    logic                      dmem_v_o;
    logic                      dmem_w_v_o;
    logic [31:0]               dmem_addr_o;
    logic [31:0]               dmem_data_o;
    logic [3:0]                dmem_mask_o;
    logic                      dmem_ready_i;
    logic                      dmem_resp_v_i;
    logic [31:0]               dmem_data_i;

    int total = 0;
    int bad   = 0;

    memory_stage #(.width_p(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stall_v_i       (stall_v_i),
        .cword_i         (cword_i),
        .alu_result_i    (alu_result_i),
        .st_data_i       (st_data_i),
        .cword_o         (cword_o),
        .rd_data_o       (rd_data_o),
        .memory_rd_data_o(memory_rd_data_o),
        .stall_v_o       (stall_v_o),
        .misaligned_v_o  (misaligned_v_o),
        .dmem_v_o        (dmem_v_o),
        .dmem_w_v_o      (dmem_w_v_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_data_o     (dmem_data_o),
        .dmem_mask_o     (dmem_mask_o),
        .dmem_ready_i    (dmem_ready_i),
        .dmem_resp_v_i   (dmem_resp_v_i),
        .dmem_data_i     (dmem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic rvga_cword mk(input logic [2:0] f3, input logic r, input logic w);
        rvga_cword c;
        c.rd_addr  = 5'd7;
        c.rd_w_v   = r;
        c.funct3   = f3;
        c.dmem_r_v = r;
        c.dmem_w_v = w;
        return c;
    endfunction

    // Clock one instruction into the stage, then hold the pipeline.
    task automatic load_instr(input rvga_cword cw, input logic [31:0] alu, input logic [31:0] st);
        cword_i      = cw;
        alu_result_i = alu;
        st_data_i    = st;
        stall_v_i    = 1'b0;
        @(posedge clk);
        #1;
        stall_v_i    = 1'b1;
        cword_i      = '0;
        alu_result_i = 32'h0;
        st_data_i    = 32'h0;
    endtask

    // Load accepted immediately, response arrives lat cycles after accept.
    task automatic run_load(input string tag, input rvga_cword cw, input logic [31:0] addr,
                            input logic [31:0] word, input int lat, input logic [31:0] exp_rd);
        int n;
        dmem_ready_i = 1'b1;
        load_instr(cw, addr, 32'h0);
        n = 0;
        for (int c = 0; c < lat; c++) begin
            #1;
            if (stall_v_o) n++;
            if (c == 0) begin
                check({tag, " req"}, 32'(dmem_v_o), 32'd1);
                check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
            end
            @(posedge clk);
            #1;
        end
        dmem_resp_v_i = 1'b1;
        dmem_data_i   = word;
        #1;
        check({tag, " stall cycles"}, 32'(n), 32'(lat));
        check({tag, " resp stall"}, 32'(stall_v_o), 32'd0);
        check({tag, " bypass"}, rd_data_o, exp_rd);
        for (int h = 0; h < 2; h++) begin
            @(posedge clk);
            #1;
            dmem_resp_v_i = 1'b0;
            dmem_data_i   = 32'h0;
            #1;
            check({tag, " held rd"}, rd_data_o, exp_rd);
            check({tag, " no reissue"}, 32'(dmem_v_o), 32'd0);
        end
    endtask

    initial begin
        int nreq;
        rst_i         = 1'b1;
        stall_v_i     = 1'b1;
        cword_i       = '0;
        alu_result_i  = 32'h0;
        st_data_i     = 32'h0;
        dmem_ready_i  = 1'b0;
        dmem_resp_v_i = 1'b0;
        dmem_data_i   = 32'h0;
        #12;
        check("reset dmem_v", 32'(dmem_v_o), 32'd0);
        check("reset mask", 32'(dmem_mask_o), 32'd0);
        check("reset stall", 32'(stall_v_o), 32'd0);
        check("reset rd", rd_data_o, 32'd0);
        check("reset cword", 32'(cword_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // ALU pass-through
        load_instr(mk(3'b000, 1'b0, 1'b0), 32'h0000_0055, 32'h0);
        #1;
        check("alu rd", rd_data_o, 32'h55);
        check("alu fwd", memory_rd_data_o, 32'h55);
        check("alu stall", 32'(stall_v_o), 32'd0);

        // sw, ready high: single handshake cycle, no stall
        dmem_ready_i = 1'b1;
        load_instr(mk(funct3_sw_lp, 1'b0, 1'b1), 32'h0000_0100, 32'hDEAD_BEEF);
        #1;
        check("sw dmem_v", 32'(dmem_v_o), 32'd1);
        check("sw w_v", 32'(dmem_w_v_o), 32'd1);
        check("sw mask", 32'(dmem_mask_o), 32'hF);
        check("sw addr", dmem_addr_o, 32'h100);
        check("sw data", dmem_data_o, 32'hDEAD_BEEF);
        check("sw stall", 32'(stall_v_o), 32'd0);
        check("sw cword", 32'(cword_o), 32'(mk(funct3_sw_lp, 1'b0, 1'b1)));
        @(posedge clk);
        #2;
        check("sw one cycle", 32'(dmem_v_o), 32'd0);

        // sb lane replication
        load_instr(mk(funct3_sb_lp, 1'b0, 1'b1), 32'h0000_0101, 32'h0000_00AB);
        #1;
        check("sb mask", 32'(dmem_mask_o), 32'h2);
        check("sb data", dmem_data_o, 32'hABAB_ABAB);

        // sh with ready low for two cycles
        dmem_ready_i = 1'b0;
        load_instr(mk(funct3_sh_lp, 1'b0, 1'b1), 32'h0000_0202, 32'h0000_1234);
        nreq = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) dmem_ready_i = 1'b1;
            #1;
            if (dmem_v_o) nreq++;
            check("sh mask", 32'(dmem_mask_o), 32'hC);
            check("sh data", dmem_data_o, 32'h1234_1234);
            check("sh addr", dmem_addr_o, 32'h200);
            check("sh stall", 32'(stall_v_o), (c == 2) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        #1;
        check("sh req cycles", 32'(nreq), 32'd3);
        check("sh done", 32'(dmem_v_o), 32'd0);

        // Loads
        run_load("lb", mk(funct3_lb_lp, 1'b1, 1'b0), 32'h0000_0103, 32'h80FF_FFFF, 4, 32'hFFFF_FF80);
        run_load("lbu", mk(funct3_lbu_lp, 1'b1, 1'b0), 32'h0000_0103, 32'h80FF_FFFF, 4, 32'h0000_0080);
        run_load("lh", mk(funct3_lh_lp, 1'b1, 1'b0), 32'h0000_0102, 32'h8001_0000, 1, 32'hFFFF_8001);
        run_load("lhu", mk(funct3_lhu_lp, 1'b1, 1'b0), 32'h0000_0102, 32'h8001_0000, 1, 32'h0000_8001);
        run_load("lw", mk(funct3_lw_lp, 1'b1, 1'b0), 32'h0000_0200, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        // Misaligned lw
        load_instr(mk(funct3_lw_lp, 1'b1, 1'b0), 32'h0000_0101, 32'h0);
        #1;
        check("lw mis flag", 32'(misaligned_v_o), 32'd1);
        check("lw mis dmem_v", 32'(dmem_v_o), 32'd0);
        check("lw mis rd", rd_data_o, 32'd0);
        check("lw mis stall", 32'(stall_v_o), 32'd0);

        // Reset while waiting for a load response
        dmem_ready_i = 1'b1;
        load_instr(mk(funct3_lw_lp, 1'b1, 1'b0), 32'h0000_0300, 32'h0);
        @(posedge clk);
        #1;
        check("wait stall", 32'(stall_v_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst dmem_v", 32'(dmem_v_o), 32'd0);
        check("rst stall", 32'(stall_v_o), 32'd0);
        check("rst rd", rd_data_o, 32'd0);
        check("rst cword", 32'(cword_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i         = 1'b0;
        dmem_resp_v_i = 1'b1;
        dmem_data_i   = 32'h1111_2222;
        #1;
        check("late resp rd", rd_data_o, 32'd0);
        check("late resp stall", 32'(stall_v_o), 32'd0);
        @(posedge clk);
        #1;
        dmem_resp_v_i = 1'b0;
        #1;
        check("late resp ignored", rd_data_o, 32'd0);
        check("late resp dmem_v", 32'(dmem_v_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
